alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multicycle MIPS control FSM that drives the ALU's control interface: 4-bit ALU operation code, operand-select muxes and datapath strobes, one instruction at a time.
- Consumes the ALU zero flag for branch resolution.
- Sits between the instruction register / memory port and the shared datapath: register file, ALU, PC.

Parameters:
- MEM_WAIT_MAX, 15: max cycles to wait for mem_ready_in before flagging a timeout; 0 disables the timeout.

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  asynchronous active-low reset
- opcode_in  input  6  IR[31:26], valid from DECODE onward
- funct_in  input  6  IR[5:0], valid from DECODE onward
- zero_in  input  1  ALU zero flag
- mem_ready_in  input  1  memory access-complete handshake
- alu_control_out  output  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
- alu_src_a_out  output  1  0 = PC, 1 = register A
- alu_src_b_out  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- pc_write_out, ir_write_out, mem_read_out, mem_write_out, iord_out, reg_write_out, reg_dst_out, mem_to_reg_out  output  1 each  datapath strobes/selects
- pc_source_out  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_out  output  1  sticky: unsupported opcode/funct seen
- timeout_out  output  1  sticky: memory wait exceeded MEM_WAIT_MAX
- state_out  output  4  current state encoding, for debug

Behaviour:
- Reset: asynchronous on rst_n_in low.
  - state = IDLE; opcode/funct latches = 0; wait counter = 0; illegal_out = 0; timeout_out = 0.
  - All outputs are 0 in IDLE.
  - IDLE -> FETCH on the first clock after reset deasserts.
  - Reset mid-instruction abandons it immediately; no strobe may stay asserted.
- Outputs are a combinational decode of the state register and latched opcode/funct. Exceptions: pc_write_out in BRANCH (follows zero_in) and the mem_ready_in-gated strobes below.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, ALU ADD, pc_source = 00.
  - Hold while mem_ready_in = 0.
  - In the cycle mem_ready_in = 1, assert ir_write and pc_write, then go to DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, ADD (branch target into ALUOut).
  - Latch opcode_in and funct_in.
  - Next state: R-type 000000 -> EXEC; lw 100011 / sw 101011 -> MEM_ADDR; beq 000100 -> BRANCH; j 000010 -> JUMP; addi 001000 -> ADDI_EX.
  - Unknown opcode, or R-type with funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt}: set illegal_out and go to FETCH. The instruction is skipped; PC was already incremented.
- EXEC: alu_src_a = 1, alu_src_b = 00; alu_control from funct (add -> 0010, sub -> 0110, and -> 0000, or -> 0001, nor -> 1100, slt -> 0111). Next: R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0; ALU code held from EXEC. Next: FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ADD. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read = 1, iord = 1; hold until mem_ready_in, then MEM_WB.
- MEM_WR: mem_write = 1, iord = 1; hold until mem_ready_in, then FETCH.
- MEM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Next: FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, ADD. Next: ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next: FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, SUB, pc_source = 01, pc_write = zero_in. Next: FETCH.
- JUMP: pc_source = 10, pc_write = 1. Next: FETCH.
- Latency from FETCH entry with mem_ready_in tied high:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3 cycles.
  - Each memory wait cycle adds 1.
- Memory-wait counter:
  - Increments each cycle a memory state waits; clears on state exit.
  - If MEM_WAIT_MAX != 0 and the count reaches MEM_WAIT_MAX: set timeout_out, drop the access, go to FETCH.
  - A FETCH timeout re-fetches without pc_write.
  - mem_ready_in in the same cycle the counter hits the limit counts as success; ready wins.
- Sticky flags clear only on reset.
- mem_read and mem_write are never both 1. pc_write and reg_write are never 1 in IDLE.

Decomposition:
- Shared package alu_defs_pkg:
  - ALU op codes (also used by the ALU)
  - opcode and funct constants
  - state enum (4-bit)
  - ALU src_b and pc_source select encodings
- Optional sub-module alu_funct_decode: combinational funct -> {alu_control, legal}.

Test Plan:
1. Reset with mem_ready_in = 1; opcode 000000, funct 100010 -> states IDLE, FETCH, DECODE, EXEC, R_WB, FETCH; alu_control = 0110 in EXEC; reg_write = 1, reg_dst = 1 only in R_WB.
2. lw (100011) with mem_ready_in low 3 cycles in MEM_RD -> mem_read = 1 and iord = 1 held 4 cycles; reg_write = 1, mem_to_reg = 1 one cycle later; 8 cycles total.
3. beq: zero_in = 1 -> pc_write = 1, pc_source = 01, alu_control = 0110 in BRANCH; repeat with zero_in = 0 -> pc_write = 0.
4. Opcode 111111, then funct 000000 with opcode 000000 -> illegal_out = 1 after DECODE, back to FETCH, no reg_write/mem_write; flag stays set.
5. MEM_WAIT_MAX = 15, mem_ready_in stuck 0 in MEM_WR -> timeout_out = 1 after 15 wait cycles, FETCH next; mem_write deasserted.
6. Assert rst_n_in low mid-MEM_RD (asynchronous, between edges) -> all outputs 0 immediately, state_out = IDLE, flags cleared.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared definitions for the multicycle MIPS control path: ALU op codes,
// instruction field constants, sequencer state encodings and mux selects.
package alu_defs_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_EXEC     = 4'd3;
  localparam logic [3:0] ST_R_WB     = 4'd4;
  localparam logic [3:0] ST_MEM_ADDR = 4'd5;
  localparam logic [3:0] ST_MEM_RD   = 4'd6;
  localparam logic [3:0] ST_MEM_WR   = 4'd7;
  localparam logic [3:0] ST_MEM_WB   = 4'd8;
  localparam logic [3:0] ST_ADDI_EX  = 4'd9;
  localparam logic [3:0] ST_ADDI_WB  = 4'd10;
  localparam logic [3:0] ST_BRANCH   = 4'd11;
  localparam logic [3:0] ST_JUMP     = 4'd12;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// Maps an R-type funct field to its ALU operation and flags unsupported functs.
module alu_funct_decode
  import alu_defs_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_AND;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle MIPS control FSM: sequences one instruction at a time and drives
// the ALU control, operand selects and datapath strobes.
module alu_sequencer
  import alu_defs_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [5:0] opcode_in,
  input  logic [5:0] funct_in,
  input  logic       zero_in,
  input  logic       mem_ready_in,
  output logic [3:0] alu_control_out,
  output logic       alu_src_a_out,
  output logic [1:0] alu_src_b_out,
  output logic       pc_write_out,
  output logic       ir_write_out,
  output logic       mem_read_out,
  output logic       mem_write_out,
  output logic       iord_out,
  output logic       reg_write_out,
  output logic       reg_dst_out,
  output logic       mem_to_reg_out,
  output logic [1:0] pc_source_out,
  output logic       illegal_out,
  output logic       timeout_out,
  output logic [3:0] state_out
);

  localparam logic [15:0] WAIT_LAST = 16'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  logic [3:0]  state;
  logic [3:0]  state_nxt;
  logic [5:0]  opcode_q;
  logic [5:0]  funct_q;
  logic [15:0] wait_cnt;
  logic        illegal_q;
  logic        timeout_q;
  logic [5:0]  funct_sel;
  logic [3:0]  funct_alu;
  logic        funct_legal;
  logic        mem_wait;
  logic        wait_expired;
  logic        set_illegal;

  // DECODE must judge the live funct field; later states use the latched copy.
  assign funct_sel = (state == ST_DECODE) ? funct_in : funct_q;

  alu_funct_decode u_funct_decode (
    .funct       (funct_sel),
    .alu_control (funct_alu),
    .legal       (funct_legal)
  );

  // A ready arriving on the limit cycle is not a wait, so ready wins.
  assign mem_wait     = is_mem_state(state) && !mem_ready_in;
  assign wait_expired = (MEM_WAIT_MAX != 0) && mem_wait && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt   = state;
    set_illegal = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (mem_ready_in) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (opcode_in)
          OP_RTYPE: begin
            if (funct_legal) begin
              state_nxt = ST_EXEC;
            end else begin
              state_nxt   = ST_FETCH;
              set_illegal = 1'b1;
            end
          end
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_BEQ:       state_nxt = ST_BRANCH;
          OP_J:         state_nxt = ST_JUMP;
          OP_ADDI:      state_nxt = ST_ADDI_EX;
          default: begin
            state_nxt   = ST_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      ST_EXEC:     state_nxt = ST_R_WB;
      ST_R_WB:     state_nxt = ST_FETCH;
      ST_MEM_ADDR: state_nxt = (opcode_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready_in)      state_nxt = ST_MEM_WB;
        else if (wait_expired) state_nxt = ST_FETCH;
      end
      ST_MEM_WR:  if (mem_ready_in || wait_expired) state_nxt = ST_FETCH;
      ST_MEM_WB:  state_nxt = ST_FETCH;
      ST_ADDI_EX: state_nxt = ST_ADDI_WB;
      ST_ADDI_WB: state_nxt = ST_FETCH;
      ST_BRANCH:  state_nxt = ST_FETCH;
      ST_JUMP:    state_nxt = ST_FETCH;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // The wait counter also clears on a FETCH timeout, which stays in FETCH.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      opcode_q  <= '0;
      funct_q   <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        opcode_q <= opcode_in;
        funct_q  <= funct_in;
      end
      if (mem_wait && !wait_expired) begin
        if (wait_cnt != '1) wait_cnt <= wait_cnt + 16'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (set_illegal)  illegal_q <= 1'b1;
      if (wait_expired) timeout_q <= 1'b1;
    end
  end

  always_comb begin
    alu_control_out = ALU_AND;
    alu_src_a_out   = 1'b0;
    alu_src_b_out   = SRC_B_REG;
    pc_write_out    = 1'b0;
    ir_write_out    = 1'b0;
    mem_read_out    = 1'b0;
    mem_write_out   = 1'b0;
    iord_out        = 1'b0;
    reg_write_out   = 1'b0;
    reg_dst_out     = 1'b0;
    mem_to_reg_out  = 1'b0;
    pc_source_out   = PC_SRC_ALU;
    case (state)
      ST_FETCH: begin
        mem_read_out    = 1'b1;
        alu_src_b_out   = SRC_B_FOUR;
        alu_control_out = ALU_ADD;
        ir_write_out    = mem_ready_in;
        pc_write_out    = mem_ready_in;
      end
      ST_DECODE: begin
        alu_src_b_out   = SRC_B_IMM_SH2;
        alu_control_out = ALU_ADD;
      end
      ST_EXEC: begin
        alu_src_a_out   = 1'b1;
        alu_control_out = funct_alu;
      end
      ST_R_WB: begin
        reg_write_out   = 1'b1;
        reg_dst_out     = 1'b1;
        alu_control_out = funct_alu;
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        alu_src_a_out   = 1'b1;
        alu_src_b_out   = SRC_B_IMM;
        alu_control_out = ALU_ADD;
      end
      ST_MEM_RD: begin
        mem_read_out = 1'b1;
        iord_out     = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_out = 1'b1;
        iord_out      = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_out  = 1'b1;
        mem_to_reg_out = 1'b1;
      end
      ST_ADDI_WB: reg_write_out = 1'b1;
      ST_BRANCH: begin
        alu_src_a_out   = 1'b1;
        alu_control_out = ALU_SUB;
        pc_source_out   = PC_SRC_ALUOUT;
        pc_write_out    = zero_in;
      end
      ST_JUMP: begin
        pc_source_out = PC_SRC_JUMP;
        pc_write_out  = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal_out = illegal_q;
  assign timeout_out = timeout_q;
  assign state_out   = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: R-type, lw with wait states, beq taken and
// not taken, illegal instructions, sw timeout and asynchronous mid-access reset.
module tb_alu_sequencer;
  import alu_defs_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [5:0] opcode_in;
  logic [5:0] funct_in;
  logic       zero_in;
  logic       mem_ready_in;
  logic [3:0] alu_control_out;
  logic       alu_src_a_out;
  logic [1:0] alu_src_b_out;
  logic       pc_write_out;
  logic       ir_write_out;
  logic       mem_read_out;
  logic       mem_write_out;
  logic       iord_out;
  logic       reg_write_out;
  logic       reg_dst_out;
  logic       mem_to_reg_out;
  logic [1:0] pc_source_out;
  logic       illegal_out;
  logic       timeout_out;
  logic [3:0] state_out;
  logic [18:0] all_out;

  int compared   = 0;
  int mismatched = 0;

  alu_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .opcode_in       (opcode_in),
    .funct_in        (funct_in),
    .zero_in         (zero_in),
    .mem_ready_in    (mem_ready_in),
    .alu_control_out (alu_control_out),
    .alu_src_a_out   (alu_src_a_out),
    .alu_src_b_out   (alu_src_b_out),
    .pc_write_out    (pc_write_out),
    .ir_write_out    (ir_write_out),
    .mem_read_out    (mem_read_out),
    .mem_write_out   (mem_write_out),
    .iord_out        (iord_out),
    .reg_write_out   (reg_write_out),
    .reg_dst_out     (reg_dst_out),
    .mem_to_reg_out  (mem_to_reg_out),
    .pc_source_out   (pc_source_out),
    .illegal_out     (illegal_out),
    .timeout_out     (timeout_out),
    .state_out       (state_out)
  );

  always #5 clk_in = ~clk_in;

  assign all_out = {alu_control_out, alu_src_a_out, alu_src_b_out, pc_write_out,
                    ir_write_out, mem_read_out, mem_write_out, iord_out,
                    reg_write_out, reg_dst_out, mem_to_reg_out, pc_source_out,
                    illegal_out, timeout_out};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic ready, input logic zero,
                               input logic [5:0] op, input logic [5:0] fn);
    @(posedge clk_in);
    #1;
    mem_ready_in = ready;
    zero_in      = zero;
    opcode_in    = op;
    funct_in     = fn;
    #1;
  endtask

  initial begin
    rst_n_in     = 1'b1;
    mem_ready_in = 1'b1;
    zero_in      = 1'b0;
    opcode_in    = OP_RTYPE;
    funct_in     = FN_SUB;
    #1 rst_n_in = 1'b0;
    repeat (2) @(negedge clk_in);
    checkOutput("reset state", 32'(state_out), 32'(ST_IDLE));
    checkOutput("reset outputs", 32'(all_out), 32'd0);
    rst_n_in = 1'b1;

    // R-type sub
    applyStimulus(1'b1, 1'b0, OP_RTYPE, FN_SUB);
    checkOutput("rtype fetch state", 32'(state_out), 32'(ST_FETCH));
    checkOutput("rtype fetch strobes {mr,iord,irw,pcw}", 32'({mem_read_out, iord_out, ir_write_out, pc_write_out}), 32'h0b);
    checkOutput("rtype fetch src_b", 32'(alu_src_b_out), 32'(SRC_B_FOUR));
    checkOutput("rtype fetch alu", 32'(alu_control_out), 32'(ALU_ADD));
    applyStimulus(1'b1, 1'b0, OP_RTYPE, FN_SUB);
    checkOutput("rtype decode state", 32'(state_out), 32'(ST_DECODE));
    checkOutput("rtype decode src_b", 32'(alu_src_b_out), 32'(SRC_B_IMM_SH2));
    applyStimulus(1'b1, 1'b0, OP_RTYPE, FN_SUB);
    checkOutput("rtype exec state", 32'(state_out), 32'(ST_EXEC));
    checkOutput("rtype exec alu", 32'(alu_control_out), 32'(ALU_SUB));
    checkOutput("rtype exec src_a", 32'(alu_src_a_out), 32'd1);
    checkOutput("rtype exec regw/dst", 32'({reg_write_out, reg_dst_out}), 32'd0);
    applyStimulus(1'b1, 1'b0, OP_RTYPE, FN_SUB);
    checkOutput("rtype wb state", 32'(state_out), 32'(ST_R_WB));
    checkOutput("rtype wb {regw,dst,m2r}", 32'({reg_write_out, reg_dst_out, mem_to_reg_out}), 32'h6);
    checkOutput("rtype wb alu held", 32'(alu_control_out), 32'(ALU_SUB));

    // lw with three wait cycles in MEM_RD
    applyStimulus(1'b1, 1'b0, OP_LW, 6'd0);
    checkOutput("lw fetch state", 32'(state_out), 32'(ST_FETCH));
    applyStimulus(1'b1, 1'b0, OP_LW, 6'd0);
    checkOutput("lw decode state", 32'(state_out), 32'(ST_DECODE));
    applyStimulus(1'b1, 1'b0, OP_LW, 6'd0);
    checkOutput("lw memaddr state", 32'(state_out), 32'(ST_MEM_ADDR));
    checkOutput("lw memaddr {src_a,src_b}", 32'({alu_src_a_out, alu_src_b_out}), 32'h6);
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i == 3), 1'b0, OP_LW, 6'd0);
      checkOutput($sformatf("lw memrd state c%0d", i), 32'(state_out), 32'(ST_MEM_RD));
      checkOutput($sformatf("lw memrd {mr,mw,iord} c%0d", i), 32'({mem_read_out, mem_write_out, iord_out}), 32'h5);
    end
    applyStimulus(1'b1, 1'b0, OP_BEQ, 6'd0);
    checkOutput("lw memwb state", 32'(state_out), 32'(ST_MEM_WB));
    checkOutput("lw memwb {regw,dst,m2r}", 32'({reg_write_out, reg_dst_out, mem_to_reg_out}), 32'h5);

    // beq taken, then not taken
    applyStimulus(1'b1, 1'b1, OP_BEQ, 6'd0);
    checkOutput("lw total 8 cycles, fetch", 32'(state_out), 32'(ST_FETCH));
    applyStimulus(1'b1, 1'b1, OP_BEQ, 6'd0);
    applyStimulus(1'b1, 1'b1, OP_BEQ, 6'd0);
    checkOutput("beq taken state", 32'(state_out), 32'(ST_BRANCH));
    checkOutput("beq taken pc_write", 32'(pc_write_out), 32'd1);
    checkOutput("beq taken pc_source", 32'(pc_source_out), 32'(PC_SRC_ALUOUT));
    checkOutput("beq taken alu", 32'(alu_control_out), 32'(ALU_SUB));
    applyStimulus(1'b1, 1'b0, OP_BEQ, 6'd0);
    checkOutput("beq2 fetch state", 32'(state_out), 32'(ST_FETCH));
    applyStimulus(1'b1, 1'b0, OP_BEQ, 6'd0);
    applyStimulus(1'b1, 1'b0, OP_BEQ, 6'd0);
    checkOutput("beq not taken state", 32'(state_out), 32'(ST_BRANCH));
    checkOutput("beq not taken pc_write", 32'(pc_write_out), 32'd0);

    // illegal opcode, then illegal R-type funct
    applyStimulus(1'b1, 1'b0, 6'b111111, 6'd0);
    checkOutput("illop fetch state", 32'(state_out), 32'(ST_FETCH));
    applyStimulus(1'b1, 1'b0, 6'b111111, 6'd0);
    checkOutput("illop decode flag", 32'(illegal_out), 32'd0);
    applyStimulus(1'b1, 1'b0, OP_RTYPE, 6'b000000);
    checkOutput("illop back to fetch", 32'(state_out), 32'(ST_FETCH));
    checkOutput("illop flag set", 32'(illegal_out), 32'd1);
    checkOutput("illop {regw,mw}", 32'({reg_write_out, mem_write_out}), 32'd0);
    applyStimulus(1'b1, 1'b0, OP_RTYPE, 6'b000000);
    checkOutput("illfn decode state", 32'(state_out), 32'(ST_DECODE));
    applyStimulus(1'b1, 1'b0, OP_SW, 6'd0);
    checkOutput("illfn back to fetch", 32'(state_out), 32'(ST_FETCH));
    checkOutput("illfn flag sticky", 32'(illegal_out), 32'd1);

    // sw with memory never ready: 15 wait cycles then timeout
    applyStimulus(1'b1, 1'b0, OP_SW, 6'd0);
    applyStimulus(1'b1, 1'b0, OP_SW, 6'd0);
    checkOutput("sw memaddr state", 32'(state_out), 32'(ST_MEM_ADDR));
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b0, 1'b0, OP_SW, 6'd0);
      checkOutput($sformatf("sw wait state c%0d", i), 32'(state_out), 32'(ST_MEM_WR));
      checkOutput($sformatf("sw wait {mw,mr,timeout} c%0d", i), 32'({mem_write_out, mem_read_out, timeout_out}), 32'h4);
    end
    applyStimulus(1'b0, 1'b0, OP_LW, 6'd0);
    checkOutput("sw timeout fetch state", 32'(state_out), 32'(ST_FETCH));
    checkOutput("sw timeout flag", 32'(timeout_out), 32'd1);
    checkOutput("sw timeout mem_write", 32'(mem_write_out), 32'd0);
    checkOutput("refetch waiting {pcw,irw}", 32'({pc_write_out, ir_write_out}), 32'd0);

    // lw interrupted by asynchronous reset in MEM_RD
    applyStimulus(1'b1, 1'b0, OP_LW, 6'd0);
    checkOutput("refetch ready pc_write", 32'(pc_write_out), 32'd1);
    applyStimulus(1'b1, 1'b0, OP_LW, 6'd0);
    applyStimulus(1'b0, 1'b0, OP_LW, 6'd0);
    applyStimulus(1'b0, 1'b0, OP_LW, 6'd0);
    checkOutput("lw2 memrd state", 32'(state_out), 32'(ST_MEM_RD));
    checkOutput("lw2 memrd mem_read", 32'(mem_read_out), 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("async reset state", 32'(state_out), 32'(ST_IDLE));
    checkOutput("async reset outputs", 32'(all_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    applyStimulus(1'b1, 1'b0, OP_LW, 6'd0);
    checkOutput("post reset fetch", 32'(state_out), 32'(ST_FETCH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
